// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and a frame-length
// helper that the receive side reuses.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   // Bit periods per frame: start + data + optional parity + stop.
   function automatic int unsigned frame_len(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
      return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; pushes when full and pops when empty are ignored.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed, configurable data width, parity and stop bits, advancing one
// bit per baud strobe with no idle gap between queued frames.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = PARITY_NONE,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clkEn,
   input  logic [DATA_BITS-1:0]              inputData,
   input  logic                              inputValid,
   output logic                              inputReady,
   output logic                              serialOutput,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount
);

   localparam int unsigned IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LastIdx = IW'(DATA_BITS - 1);

   tx_state_e            r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [IW-1:0]        r_idx;
   logic                 r_stop_cnt;
   logic                 r_tx;

   logic [DATA_BITS-1:0] w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_stop_last;
   logic                 w_par;

   assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_push      = inputValid && !w_full && !reset;
   // Pop only on the strobe that launches a new start bit.
   assign w_pop       = clkEn && !w_empty &&
                        ((r_state == StIdle) || ((r_state == StStop) && w_stop_last));
   assign w_par       = (PARITY == PARITY_ODD) ? ~(^r_shift) : ^r_shift;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (inputData),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (fifoCount),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_shift    <= '0;
         r_idx      <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
      end else if (clkEn) begin
         case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= StStart;
               end
            end
            StStart: begin
               r_tx    <= r_shift[0];
               r_idx   <= '0;
               r_state <= StData;
            end
            StData: begin
               if (r_idx == LastIdx) begin
                  r_stop_cnt <= 1'b0;
                  if (PARITY != PARITY_NONE) begin
                     r_tx    <= w_par;
                     r_state <= StParity;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= StStop;
                  end
               end else begin
                  r_idx <= r_idx + IW'(1);
                  r_tx  <= r_shift[r_idx + IW'(1)];
               end
            end
            StParity: begin
               r_tx       <= 1'b1;
               r_stop_cnt <= 1'b0;
               r_state    <= StStop;
            end
            StStop: begin
               if (!w_stop_last) begin
                  r_stop_cnt <= r_stop_cnt + 1'b1;
                  r_tx       <= 1'b1;
               end else if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= StStart;
               end else begin
                  r_tx    <= 1'b1;
                  r_state <= StIdle;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign serialOutput = r_tx;
   assign inputReady   = !w_full;
   assign busy         = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three parameterisations share stimulus and are compared every
// cycle against a frame-level model (word queue plus precomputed bit list per frame).
module tb_uart_tx_param;

   localparam int unsigned NDUT = 3;
   localparam int unsigned DB0 = 8, PA0 = 0, SB0 = 1, FD0 = 4;
   localparam int unsigned DB1 = 7, PA1 = 2, SB1 = 2, FD1 = 4;
   localparam int unsigned DB2 = 5, PA2 = 1, SB2 = 1, FD2 = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       clkEn;
   logic       in_valid;
   logic [8:0] in_data;
   logic [2:0] ser;
   logic [2:0] bsy;
   logic [2:0] rdy;
   logic [2:0] cnt0;
   logic [2:0] cnt1;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   uart_tx_param #(.DATA_BITS(DB0), .PARITY(PA0), .STOP_BITS(SB0), .FIFO_DEPTH(FD0)) u0 (
      .clk(clk), .reset(reset), .clkEn(clkEn), .inputData(in_data[DB0-1:0]),
      .inputValid(in_valid), .inputReady(rdy[0]), .serialOutput(ser[0]), .busy(bsy[0]),
      .fifoCount(cnt0));
   uart_tx_param #(.DATA_BITS(DB1), .PARITY(PA1), .STOP_BITS(SB1), .FIFO_DEPTH(FD1)) u1 (
      .clk(clk), .reset(reset), .clkEn(clkEn), .inputData(in_data[DB1-1:0]),
      .inputValid(in_valid), .inputReady(rdy[1]), .serialOutput(ser[1]), .busy(bsy[1]),
      .fifoCount(cnt1));
   uart_tx_param #(.DATA_BITS(DB2), .PARITY(PA2), .STOP_BITS(SB2), .FIFO_DEPTH(FD2)) u2 (
      .clk(clk), .reset(reset), .clkEn(clkEn), .inputData(in_data[DB2-1:0]),
      .inputValid(in_valid), .inputReady(rdy[2]), .serialOutput(ser[2]), .busy(bsy[2]),
      .fifoCount(cnt2));

   int unsigned db[NDUT], pa[NDUT], sb[NDUT], fd[NDUT];
   int unsigned q[NDUT][$];
   logic        fbits[NDUT][16];
   int unsigned flen[NDUT], pos[NDUT];
   bit          active[NDUT];
   logic        smp[NDUT][$];
   int unsigned n_total = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void build_frame(input int k, input int unsigned w);
      int unsigned n;
      bit p;
      p = 1'b0;
      fbits[k][0] = 1'b0;
      for (int i = 0; i < int'(db[k]); i++) begin
         fbits[k][1+i] = w[i];
         p ^= w[i];
      end
      n = 1 + db[k];
      if (pa[k] != 0) begin
         fbits[k][n] = (pa[k] == 2) ? p : !p;
         n++;
      end
      for (int s = 0; s < int'(sb[k]); s++) begin
         fbits[k][n] = 1'b1;
         n++;
      end
      flen[k] = n;
   endfunction

   // Advance the model by one clock edge using the inputs that were present at that edge.
   task automatic model_edge();
      for (int k = 0; k < NDUT; k++) begin
         if (reset) begin
            q[k].delete();
            active[k] = 1'b0;
            pos[k]    = 0;
         end else begin
            int unsigned pre;
            pre = q[k].size();
            if (clkEn) begin
               if (active[k] && (pos[k] + 1 < flen[k])) begin
                  pos[k]++;
               end else if (pre != 0) begin
                  build_frame(k, q[k].pop_front());
                  pos[k]    = 0;
                  active[k] = 1'b1;
               end else begin
                  active[k] = 1'b0;
               end
            end
            if (in_valid && (pre != fd[k]))
               q[k].push_back(int'(in_data) & ((1 << db[k]) - 1));
         end
      end
   endtask

   function automatic logic exp_line(input int k);
      return active[k] ? fbits[k][pos[k]] : 1'b1;
   endfunction

   function automatic logic [31:0] cnt_of(input int k);
      case (k)
         0:       return 32'(cnt0);
         1:       return 32'(cnt1);
         default: return 32'(cnt2);
      endcase
   endfunction

   task automatic compare_all();
      for (int k = 0; k < NDUT; k++) begin
         check_eq($sformatf("u%0d.line", k), 32'(ser[k]), 32'(exp_line(k)));
         check_eq($sformatf("u%0d.busy", k), 32'(bsy[k]),
                  32'(active[k] || (q[k].size() != 0)));
         check_eq($sformatf("u%0d.count", k), cnt_of(k), q[k].size());
         check_eq($sformatf("u%0d.ready", k), 32'(rdy[k]), 32'(q[k].size() != fd[k]));
      end
   endtask

   task automatic tick(input logic v, input logic [8:0] d, input logic en, input logic rst);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      clkEn    = en;
      reset    = rst;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      if (en) for (int k = 0; k < NDUT; k++) smp[k].push_back(ser[k]);
   endtask

   task automatic clear_samples();
      for (int k = 0; k < NDUT; k++) smp[k].delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((bsy != 3'b000) && (n < 400)) begin
         tick(1'b0, 9'h0, 1'b1, 1'b0);
         n++;
      end
      check_eq("drain.busy", 32'(bsy), 32'd0);
   endtask

   initial begin
      logic [9:0] exp_a5;
      int unsigned errs;
      db = '{DB0, DB1, DB2};
      pa = '{PA0, PA1, PA2};
      sb = '{SB0, SB1, SB2};
      fd = '{FD0, FD1, FD2};
      in_valid = 1'b0;
      in_data  = '0;
      clkEn    = 1'b0;
      reset    = 1'b1;

      for (int i = 0; i < 3; i++) tick(1'b0, 9'h0, 1'b0, 1'b1);
      check_eq("rst.line", 32'(ser[0]), 32'd1);
      check_eq("rst.busy", 32'(bsy[0]), 32'd0);
      check_eq("rst.count", 32'(cnt0), 32'd0);
      check_eq("rst.ready", 32'(rdy[0]), 32'd1);

      // 0xA5 with a strobe every 4 clocks.
      clear_samples();
      tick(1'b1, 9'h0A5, 1'b0, 1'b0);
      for (int i = 0; i < 48; i++) tick(1'b0, 9'h0, 1'b0 | ((i % 4) == 3), 1'b0);
      exp_a5 = 10'b1101001010;
      check_eq("a5.nsmp", smp[0].size(), 32'd12);
      if (smp[0].size() >= 10)
         for (int i = 0; i < 10; i++)
            check_eq($sformatf("a5.bit%0d", i), 32'(smp[0][i]), 32'(exp_a5[i]));
      check_eq("a5.busy_end", 32'(bsy[0]), 32'd0);

      // Parity and stop bits: 0x13 on the 7-bit even and 5-bit odd instances.
      clear_samples();
      tick(1'b1, 9'h013, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tick(1'b0, 9'h0, 1'b1, 1'b0);
      check_eq("par.even7", 32'(smp[1][8]), 32'd1);
      check_eq("par.stop1", 32'(smp[1][9]), 32'd1);
      check_eq("par.stop2", 32'(smp[1][10]), 32'd1);
      check_eq("par.odd5", 32'(smp[2][6]), 32'd0);
      drain();

      // Fill the FIFO with no strobes, then stream back-to-back.
      clear_samples();
      for (int i = 1; i <= 5; i++) tick(1'b1, 9'(i), 1'b0, 1'b0);
      check_eq("fill.ready", 32'(rdy[0]), 32'd0);
      check_eq("fill.count", 32'(cnt0), 32'd4);
      tick(1'b1, 9'h005, 1'b1, 1'b0);
      check_eq("fill.fullpop", 32'(cnt0), 32'd3);
      tick(1'b1, 9'h005, 1'b1, 1'b0);
      for (int i = 0; i < 60; i++) tick(1'b0, 9'h0, 1'b1, 1'b0);
      check_eq("b2b.nsmp_ok", 32'(smp[0].size() >= 50), 32'd1);
      if (smp[0].size() >= 50) begin
         for (int f = 0; f < 5; f++) begin
            logic [7:0] b;
            for (int i = 0; i < 8; i++) b[i] = smp[0][10*f+1+i];
            check_eq($sformatf("b2b.start%0d", f), 32'(smp[0][10*f]), 32'd0);
            check_eq($sformatf("b2b.data%0d", f), 32'(b), 32'(f + 1));
            check_eq($sformatf("b2b.stop%0d", f), 32'(smp[0][10*f+9]), 32'd1);
         end
      end
      drain();

      // Push coincident with an idle strobe: start bit waits for the next strobe.
      tick(1'b1, 9'h03C, 1'b1, 1'b0);
      check_eq("defer.line", 32'(ser[0]), 32'd1);
      check_eq("defer.count", 32'(cnt0), 32'd1);
      check_eq("defer.busy", 32'(bsy[0]), 32'd1);
      tick(1'b0, 9'h0, 1'b1, 1'b0);
      check_eq("defer.start", 32'(ser[0]), 32'd0);
      drain();

      // Reset in the middle of a 0xFF data phase with two words queued.
      tick(1'b1, 9'h0FF, 1'b0, 1'b0);
      tick(1'b1, 9'h011, 1'b0, 1'b0);
      tick(1'b1, 9'h022, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 9'h0, 1'b1, 1'b0);
      check_eq("mid.count", 32'(cnt0), 32'd2);
      check_eq("mid.line", 32'(ser[0]), 32'd1);
      tick(1'b1, 9'h055, 1'b1, 1'b1);
      check_eq("mrst.line", 32'(ser[0]), 32'd1);
      check_eq("mrst.count", 32'(cnt0), 32'd0);
      check_eq("mrst.busy", 32'(bsy[0]), 32'd0);
      check_eq("mrst.ready", 32'(rdy[0]), 32'd1);
      errs = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 9'h0, 1'b1, 1'b0);
         if (ser[0] !== 1'b1) errs++;
      end
      check_eq("mrst.residual", errs, 32'd0);

      // Strobe gap of 50 cycles while data bit 3 of 0xB6 (a 0) is on the line.
      tick(1'b1, 9'h0B6, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 9'h0, 1'b1, 1'b0);
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 9'h0, 1'b0, 1'b0);
         if (ser[0] !== 1'b0) errs++;
      end
      check_eq("gap.hold", errs, 32'd0);
      tick(1'b0, 9'h0, 1'b1, 1'b0);
      check_eq("gap.resume", 32'(ser[0]), 32'd1);
      drain();

      // Random traffic, alternating sparse strobes and strobe-every-cycle phases.
      for (int i = 0; i < 3000; i++) begin
         logic en;
         en = (((i / 500) % 2) == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
         tick(1'($urandom_range(0, 1)), 9'($urandom), en, 1'($urandom_range(0, 299) == 0));
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO, configurable frame format (data width, optional parity, one or two stop bits) and a valid/ready write port. It sits between a parallel producer and the serial pin. It shares the system clock with a baud generator that supplies a one-cycle `clkEn` strobe once per bit period. Back-to-back frames are sent without idle gaps while the FIFO holds data.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values 1 or 2.
- `FIFO_DEPTH`, 4: word capacity; power of two, ≥2.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clkEn`  in  1  baud strobe; one `clk` wide, once per bit period; may be high every cycle.
- `inputData`  in  DATA_BITS  word to transmit.
- `inputValid`  in  1  producer offers `inputData`.
- `inputReady`  out  1  FIFO can accept; equals (fifoCount != FIFO_DEPTH).
- `serialOutput`  out  1  TX line, idle high.
- `busy`  out  1  (state != IDLE) or (fifoCount != 0).
- `fifoCount`  out  $clog2(FIFO_DEPTH+1)  words queued, not counting the frame on the line.

## Operation
- Push: the word is accepted on a rising edge where `inputValid && inputReady`. No push occurs while `reset` is high.
- Line changes only on cycles with `clkEn`=1, so every bit lasts exactly one strobe period.
- Frame order: start (0), data LSB first, parity (if enabled), then STOP_BITS ones.
- Parity: even = XOR of data bits; odd = its inverse.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `clkEn` with fifoCount≠0, pop the head into the shift register, drive 0, go to START.
  - START: on `clkEn`, drive data[0], set bit index 0, go to DATA.
  - DATA: on `clkEn`, if index = DATA_BITS−1, drive parity and go to PARITY (or drive 1 and go to STOP if PARITY=0); otherwise increment the index and drive the next bit.
  - PARITY: on `clkEn`, drive 1, set stop count 0, go to STOP.
  - STOP: on `clkEn`, if stop count < STOP_BITS−1, increment it and hold 1. Otherwise the frame ends:
    - FIFO non-empty: pop, drive 0, go to START (no idle bit).
    - FIFO empty: hold 1 and go to IDLE.
- Without a `clkEn` strobe, state and line hold.

## Timing
- Reset values: `serialOutput`=1, `busy`=0, `fifoCount`=0, `inputReady`=1, state IDLE. The FIFO is flushed, and any frame in flight is abandoned with the line forced high on the next edge.
- Push-to-line latency: a word pushed at edge t is poppable from cycle t+1. The start bit begins on the first `clkEn` edge after t; a strobe coincident with edge t does not pop it.
- Push and pop on the same edge when full: `inputReady` is 0 (pre-pop count), so no push occurs and the count decreases by 1.
- Push and pop on the same edge otherwise: the count is unchanged.
- Frame length: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS strobe periods.
- With `clkEn` tied high, one bit per `clk`, and back-to-back frames are seamless.
- `busy` rises the cycle after the first push and falls the cycle after the final stop edge with the FIFO empty.

## Structure
- Package `uart_pkg` holds:
  - Parity constants PARITY_NONE/ODD/EVEN.
  - The TX state encoding.
  - A shared frame-length function for the RX side.
- Sub-module `uart_sync_fifo` (params WIDTH, DEPTH; ports push/pop/data/count) provides a reusable synchronous FIFO. The TX FSM instantiates it once.

## Test plan
- Defaults, `clkEn` every 4 cycles, push 0xA5: line shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 clk; `busy` drops after the stop bit.
- PARITY=2, DATA_BITS=7, push 0x13: the parity bit is 1. With PARITY=1 the parity bit is 0. STOP_BITS=2 gives 2 high periods.
- FIFO_DEPTH=4, `clkEn` high every cycle, push 5 words back-to-back:
  - `inputReady` drops at count 4 while no frame is popping.
  - Frames 0x01..0x05 appear with no idle bits between them.
- Push on the same edge as an IDLE `clkEn`: the start bit is deferred to the next strobe.
- Assert `reset` mid-DATA of 0xFF with 2 words queued: the next cycle shows line=1, count=0, `busy`=0, `inputReady`=1, and no residual frame is sent.
- Hold `clkEn` low for 50 cycles mid-frame: the line holds its current bit, and transmission resumes exactly where it stopped.
